// File: rtl/muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO; the divider is present only when MULDIV_DIV_EN is defined.
// Latency is 34 cycles from start to done; busy covers the whole operation and start/MTHI/MTLO are ignored while busy.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] tg,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   sr_q, sr_d, tg_q, tg_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, done_q, done_d;

    logic               signed_op;
    logic [WIDTH-1:0]   sr_abs, tg_abs;
    logic [WIDTH-1:0]   add_a, add_b, add_res;
    logic               add_cin, add_cf;
    logic [WIDTH-1:0]   mul_sum;
    logic               mul_c;
    logic [2*WIDTH-1:0] prod;

    assign signed_op = ~op_q[0];
    assign sr_abs    = (signed_op && sr_q[WIDTH-1]) ? -sr_q : sr_q;
    assign tg_abs    = (signed_op && tg_q[WIDTH-1]) ? -tg_q : tg_q;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] rem_sh;
    logic             div_ok;

    // Shifted partial remainder is 33 bits wide; a set top bit means the trial subtract cannot borrow.
    assign rem_sh  = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
    assign div_ok  = add_cf | acc_hi_q[WIDTH-1];
    assign add_a   = op_q[1] ? rem_sh : acc_hi_q;
    assign add_b   = op_q[1] ? ~mcand_q : mcand_q;
    assign add_cin = op_q[1];
`else
    assign add_a   = acc_hi_q;
    assign add_b   = mcand_q;
    assign add_cin = 1'b0;
`endif

    Add u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .res (add_res),
        .CF  (add_cf)
    );

    assign mul_sum = acc_lo_q[0] ? add_res : acc_hi_q;
    assign mul_c   = acc_lo_q[0] & add_cf;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sr_d     = sr_q;
        tg_d     = tg_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        prod     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    sr_d = sr;
                    tg_d = tg;
`ifdef MULDIV_DIV_EN
                    state_d = PREP;
`else
                    state_d = op[1] ? FIX : PREP;
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            PREP: begin
                neg_d    = signed_op & (sr_q[WIDTH-1] ^ tg_q[WIDTH-1]);
                acc_hi_d = '0;
                cnt_d    = '0;
                mcand_d  = sr_abs;
                acc_lo_d = tg_abs;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    mcand_d  = tg_abs;
                    acc_lo_d = sr_abs;
                end
`endif
                state_d = RUN;
            end
            RUN: begin
                cnt_d    = cnt_q + CW'(1);
                acc_hi_d = {mul_c, mul_sum[WIDTH-1:1]};
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    acc_hi_d = div_ok ? add_res : rem_sh;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
                end
`endif
                if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                prod    = {acc_hi_q, acc_lo_q};
                if (neg_q) prod = -prod;
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
`ifdef MULDIV_DIV_EN
                else if (tg_q == '0) begin
                    lo_d = '1;
                    hi_d = sr_q;
                end else begin
                    lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                    hi_d = (signed_op && sr_q[WIDTH-1]) ? -acc_hi_q : acc_hi_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sr_q     <= '0;
            tg_q     <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sr_q     <= sr_d;
            tg_q     <= tg_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// 32-bit adder with carry-in and carry-out, shared by the multiply and divide iterations.
module Add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] res,
    output logic        CF
);
    assign {CF, res} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule
